// File: rtl/wb_gain_apply.sv
// White-balance gain stage for a raw Bayer stream: scales blue/red pixels by
// frame-synchronous gains (shadowed until sof) and passes green through.
module wb_gain_apply #(
  parameter int DW   = 8,
  parameter int GW   = 18,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gain_load,
  input  logic [GW-1:0] bk_in,
  input  logic [GW-1:0] rk_in,
  input  logic          bypass,
  input  logic          sof,
  input  logic          eol,
  input  logic          data_in_valid,
  input  logic [DW-1:0] data_in,
  output logic          data_out_valid,
  output logic [DW-1:0] data_out,
  output logic          sof_out,
  output logic          eol_out
);

  localparam int PW = DW + GW;
  localparam int RW = PW - FRAC;
  localparam logic [GW-1:0] UNITY = GW'(1) << FRAC;

  logic [GW-1:0] pend_b_q, pend_b_d, pend_r_q, pend_r_d;
  logic [GW-1:0] act_b_q, act_b_d, act_r_q, act_r_d;
  logic          x_q, x_d, y_q, y_d;

  logic [DW-1:0] s1_pix_q, s1_pix_d;
  logic [GW-1:0] s1_gain_q, s1_gain_d;
  logic          s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;

  logic [DW-1:0] data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d, sof_out_q, sof_out_d, eol_out_q, eol_out_d;

  logic          frame_start, x_eff, y_eff, is_blue, is_red;
  logic [PW-1:0] prod;
  logic [RW-1:0] res;
  logic          sat;

  // Gain shadowing and Bayer parity tracking.
  always_comb begin
    frame_start = data_in_valid & sof;
    pend_b_d    = gain_load ? bk_in : pend_b_q;
    pend_r_d    = gain_load ? rk_in : pend_r_q;
    // A load coinciding with sof flows straight through pend into act.
    act_b_d     = frame_start ? pend_b_d : act_b_q;
    act_r_d     = frame_start ? pend_r_d : act_r_q;

    x_eff   = sof ? 1'b0 : x_q;
    y_eff   = sof ? 1'b0 : y_q;
    is_blue = ~x_eff & ~y_eff;
    is_red  = x_eff & y_eff;

    x_d = x_q;
    y_d = y_q;
    if (data_in_valid) begin
      if (eol) begin
        x_d = 1'b0;
        y_d = ~y_eff;
      end else begin
        x_d = ~x_eff;
        y_d = y_eff;
      end
    end
  end

  // Stage 1: pixel plus the gain it will be multiplied by.
  always_comb begin
    s1_valid_d = data_in_valid;
    s1_sof_d   = data_in_valid & sof;
    s1_eol_d   = data_in_valid & eol;
    s1_pix_d   = s1_pix_q;
    s1_gain_d  = s1_gain_q;
    if (data_in_valid) begin
      s1_pix_d = data_in;
      if (bypass)       s1_gain_d = UNITY;
      else if (is_blue) s1_gain_d = act_b_d;
      else if (is_red)  s1_gain_d = act_r_d;
      else              s1_gain_d = UNITY;
    end
  end

  // Stage 2: multiply, drop fractional bits (truncate), saturate.
  always_comb begin
    prod        = PW'(s1_pix_q) * PW'(s1_gain_q);
    res         = prod[PW-1:FRAC];
    sat         = |res[RW-1:DW];
    valid_out_d = s1_valid_q;
    sof_out_d   = s1_sof_q;
    eol_out_d   = s1_eol_q;
    data_out_d  = data_out_q;
    if (s1_valid_q) data_out_d = sat ? {DW{1'b1}} : res[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_b_q    <= UNITY;
      pend_r_q    <= UNITY;
      act_b_q     <= UNITY;
      act_r_q     <= UNITY;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      s1_pix_q    <= '0;
      s1_gain_q   <= UNITY;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      eol_out_q   <= 1'b0;
    end else begin
      pend_b_q    <= pend_b_d;
      pend_r_q    <= pend_r_d;
      act_b_q     <= act_b_d;
      act_r_q     <= act_r_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s1_pix_q    <= s1_pix_d;
      s1_gain_q   <= s1_gain_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
      eol_out_q   <= eol_out_d;
    end
  end

  assign data_out_valid = valid_out_q;
  assign data_out       = data_out_q;
  assign sof_out        = sof_out_q;
  assign eol_out        = eol_out_q;

endmodule

// File: tb/tb_wb_gain_apply.sv
// Directed bench for wb_gain_apply: stimulus pushes expected pixels into a
// queue, a negedge monitor pops and compares whatever the DUT emits.
module tb_wb_gain_apply;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gain_load = 1'b0;
  logic [17:0] bk_in = '0, rk_in = '0;
  logic        bypass = 1'b0, sof = 1'b0, eol = 1'b0, data_in_valid = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_out_valid, sof_out, eol_out;
  logic [7:0]  data_out;

  wb_gain_apply #(.DW(8), .GW(18), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .gain_load(gain_load), .bk_in(bk_in), .rk_in(rk_in),
    .bypass(bypass), .sof(sof), .eol(eol), .data_in_valid(data_in_valid),
    .data_in(data_in), .data_out_valid(data_out_valid), .data_out(data_out),
    .sof_out(sof_out), .eol_out(eol_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         s;
    bit         e;
    int         c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   byp = 1'b0;
  bit   co_load = 1'b0;
  logic [17:0] co_bk = '0, co_rk = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && data_out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data_out", int'(data_out), int'(e.d));
        check("sof_out", int'(sof_out), int'(e.s));
        check("eol_out", int'(eol_out), int'(e.e));
        check("latency_cycle", cyc, e.c);
        $display("pix out=%0d exp=%0d sof=%0b eol=%0b cyc=%0d", data_out, e.d, sof_out, eol_out, cyc);
      end
    end
  end

  task automatic px(input logic [7:0] p, input bit s, input bit e,
                    input logic [7:0] ex, input bit chk = 1'b1);
    exp_t it;
    @(negedge clk);
    data_in_valid = 1'b1;
    data_in = p;
    sof = s;
    eol = e;
    bypass = byp;
    gain_load = co_load;
    bk_in = co_bk;
    rk_in = co_rk;
    co_load = 1'b0;
    if (chk) begin
      it.d = ex; it.s = s; it.e = e; it.c = cyc + 2;
      q.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      sof = 1'b0;
      eol = 1'b0;
      gain_load = 1'b0;
      bypass = 1'b0;
    end
  endtask

  task automatic load(input logic [17:0] b, input logic [17:0] r);
    @(negedge clk);
    data_in_valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
    gain_load = 1'b1;
    bk_in = b;
    rk_in = r;
    @(negedge clk);
    gain_load = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", int'(data_out_valid), 0);
    check("reset_data", int'(data_out), 0);
    rst_n = 1'b1;

    // Unity gains after reset.
    px(100, 1, 0, 100); px(100, 0, 0, 100); px(100, 0, 0, 100); px(100, 0, 1, 100);
    px(100, 0, 0, 100); px(100, 0, 0, 100); px(100, 0, 0, 100); px(100, 0, 1, 100);
    idle(2);

    // Blue x2, red x0.5.
    load(512, 128);
    px(40, 1, 0, 80); px(50, 0, 0, 50); px(40, 0, 0, 80); px(50, 0, 1, 50);
    px(60, 0, 0, 60); px(80, 0, 0, 40); px(60, 0, 0, 60); px(80, 0, 1, 40);
    idle(2);

    // Saturation and truncation.
    load(1024, 257);
    px(200, 1, 0, 255); px(10, 0, 1, 10);
    px(30, 0, 0, 30);   px(255, 0, 1, 255);
    px(5, 0, 0, 20);    px(6, 0, 1, 6);
    px(7, 0, 0, 7);     px(100, 0, 1, 100);
    idle(2);

    // Mid-frame load must not take effect until the next sof.
    load(256, 128);
    px(10, 1, 0, 10); px(20, 0, 1, 20);
    px(30, 0, 0, 30); px(100, 0, 1, 50);
    load(256, 512);
    px(10, 0, 0, 10); px(20, 0, 1, 20);
    px(30, 0, 0, 30); px(100, 0, 1, 50);
    px(10, 1, 0, 10); px(20, 0, 1, 20);
    px(30, 0, 0, 30); px(100, 0, 1, 200);
    // Load coincident with sof applies to that same frame.
    co_load = 1'b1; co_bk = 768; co_rk = 64;
    px(10, 1, 0, 30); px(20, 0, 1, 20);
    px(30, 0, 0, 30); px(100, 0, 1, 25);
    idle(2);

    // Gapped input with sof and eol on the same pixel.
    px(10, 1, 1, 30); idle(1);
    px(50, 0, 0, 50); idle(1);
    px(100, 0, 1, 25); idle(1);
    px(20, 0, 0, 60); idle(1);
    px(21, 0, 1, 21);
    idle(3);

    // Reset with pixels in flight.
    load(256, 512);
    px(10, 1, 0, 10);
    px(20, 0, 0, 0, 1'b0);
    px(30, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    check("inflight_valid", int'(data_out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(data_out_valid), 0);
    check("async_reset_data", int'(data_out), 0);
    idle(3);
    rst_n = 1'b1;
    // No sof: parity starts at (0,0), gains are unity.
    px(100, 0, 0, 100); px(100, 0, 1, 100);
    px(50, 0, 0, 50);   px(100, 0, 1, 100);
    idle(2);

    // Bypass on a red pixel, then the same pixel scaled.
    load(256, 512);
    px(10, 1, 0, 10); px(20, 0, 1, 20);
    px(30, 0, 0, 30);
    byp = 1'b1; px(100, 0, 1, 100); byp = 1'b0;
    px(1, 0, 0, 1);   px(2, 0, 1, 2);
    px(3, 0, 0, 3);   px(100, 0, 1, 200);
    idle(6);

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
